// File: rtl/fnd_pkg.sv
// Shared types and helpers for the FND page scheduler.
package fnd_pkg;

   localparam int DEF_NUM_PAGES = 6;
   localparam int DEF_DATA_W    = 8;

   typedef enum logic [1:0] {
      IDLE,
      MANUAL,
      AUTO_SHOW,
      AUTO_BLANK
   } state_t;

   // Returns {valid, idx}; valid needs exactly one bit set below n.
   function automatic logic [3:0] onehot_to_idx(
      input logic [6:0] oh,
      input int         n
   );
      logic [2:0] idx;
      int         cnt;
      idx = '0;
      cnt = 0;
      for (int i = 0; i < 7; i++) begin
         if (oh[i]) begin
            idx = 3'(i);
            cnt++;
         end
      end
      return {(cnt == 1) && (int'(idx) < n), idx};
   endfunction

endpackage

// File: rtl/fnd_page_scheduler_if.sv
// Bus between the register bank side and the page scheduler.
interface fnd_page_scheduler_if #(
   parameter int NUM_PAGES = 6,
   parameter int DATA_W    = 8
);
   logic [6:0]                  sw;
   logic                        auto_en;
   logic                        hold;
   logic [NUM_PAGES*DATA_W-1:0] page_data;
   logic [DATA_W-1:0]           digit;
   logic [2:0]                  page_idx;
   logic                        blank;
   logic                        page_tick;

   modport master (
      output sw, auto_en, hold, page_data,
      input  digit, page_idx, blank, page_tick
   );

   modport slave (
      input  sw, auto_en, hold, page_data,
      output digit, page_idx, blank, page_tick
   );
endinterface

// File: rtl/fnd_dwell_timer.sv
// Terminal-count timer with a runtime choice of dwell or blank limit.
module fnd_dwell_timer #(
   parameter int DWELL_CYCLES = 4,
   parameter int BLANK_CYCLES = 2,
   parameter int CW           = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   input  logic sel_blank,
   output logic tc
);
   localparam logic [CW-1:0] DWELL_LIM = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LIM =
      CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

   logic [CW-1:0] cnt;
   logic [CW-1:0] lim;

   assign lim = sel_blank ? BLANK_LIM : DWELL_LIM;
   assign tc  = en && !clr && (cnt == lim);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + 1'b1;
      end
   end
endmodule

// File: rtl/fnd_page_scheduler.sv
// Chooses which status page drives the FND: manual one-hot or auto-rotate.
module fnd_page_scheduler
   import fnd_pkg::*;
#(
   parameter int NUM_PAGES    = DEF_NUM_PAGES,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int DWELL_CYCLES = 100_000_000,
   parameter int BLANK_CYCLES = 10_000_000
) (
   input logic                  clk,
   input logic                  reset,
   fnd_page_scheduler_if.slave  bus
);
   localparam int MAXC0 =
      (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int MAXC = (MAXC0 > 2) ? MAXC0 : 2;
   localparam int CW   = $clog2(MAXC);
   localparam logic [2:0] LAST = 3'(NUM_PAGES - 1);

   state_t            state, nstate;
   logic [2:0]        pidx, npidx, adv;
   logic [DATA_W-1:0] digit_q, ndigit;
   logic              blank_q, tick_q, ntick;
   logic              sv;
   logic [2:0]        sidx;
   logic              tc, clr, in_auto;
   logic [DATA_W-1:0] pages [NUM_PAGES];

   for (genvar k = 0; k < NUM_PAGES; k++) begin : g_pg
      assign pages[k] = bus.page_data[k*DATA_W +: DATA_W];
   end

   assign {sv, sidx} = onehot_to_idx(bus.sw, NUM_PAGES);
   assign in_auto = (state == AUTO_SHOW) || (state == AUTO_BLANK);
   // Counter only runs while staying in an auto state.
   assign clr = sv || !bus.auto_en || !in_auto;

   fnd_dwell_timer #(
      .DWELL_CYCLES (DWELL_CYCLES),
      .BLANK_CYCLES (BLANK_CYCLES),
      .CW           (CW)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .en        (!bus.hold),
      .clr       (clr),
      .sel_blank (state == AUTO_BLANK),
      .tc        (tc)
   );

   always_comb begin
      nstate = state;
      npidx  = pidx;
      ntick  = 1'b0;
      adv    = (pidx == LAST) ? 3'd0 : pidx + 3'd1;
      if (sv) begin
         nstate = MANUAL;
         npidx  = sidx;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.auto_en) nstate = AUTO_SHOW;
            end
            MANUAL: begin
               nstate = bus.auto_en ? AUTO_SHOW : IDLE;
            end
            AUTO_SHOW: begin
               if (!bus.auto_en) begin
                  nstate = IDLE;
               end else if (tc) begin
                  if (BLANK_CYCLES > 0) begin
                     nstate = AUTO_BLANK;
                  end else begin
                     npidx = adv;
                     ntick = 1'b1;
                  end
               end
            end
            AUTO_BLANK: begin
               if (!bus.auto_en) begin
                  nstate = IDLE;
               end else if (tc) begin
                  nstate = AUTO_SHOW;
                  npidx  = adv;
                  ntick  = 1'b1;
               end
            end
            default: nstate = IDLE;
         endcase
      end
      ndigit = (nstate == IDLE) ? '0 : pages[npidx];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pidx    <= '0;
         digit_q <= '0;
         blank_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state   <= nstate;
         pidx    <= npidx;
         digit_q <= ndigit;
         blank_q <= (nstate == AUTO_BLANK);
         tick_q  <= ntick;
      end
   end

   assign bus.digit     = digit_q;
   assign bus.page_idx  = pidx;
   assign bus.blank     = blank_q;
   assign bus.page_tick = tick_q;
endmodule

// File: tb/tb_fnd_page_scheduler.sv
// Directed bench for fnd_page_scheduler with short dwell/blank settings.
module tb_fnd_page_scheduler;
   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   fnd_page_scheduler_if #(.NUM_PAGES(6), .DATA_W(8)) b0 ();
   fnd_page_scheduler_if #(.NUM_PAGES(6), .DATA_W(8)) b1 ();

   fnd_page_scheduler #(
      .NUM_PAGES(6), .DATA_W(8), .DWELL_CYCLES(4), .BLANK_CYCLES(2)
   ) u0 (.clk(clk), .reset(reset), .bus(b0.slave));

   fnd_page_scheduler #(
      .NUM_PAGES(6), .DATA_W(8), .DWELL_CYCLES(4), .BLANK_CYCLES(0)
   ) u1 (.clk(clk), .reset(reset), .bus(b1.slave));

   typedef struct {
      logic [6:0] sw;
      logic       ae;
      logic       hold;
      logic [2:0] idx;
      logic [7:0] digit;
      logic       blank;
      logic       tick;
   } vec_t;

   vec_t tv [21];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic [2:0] idx,
                          input logic [7:0] d, input logic bl,
                          input logic tk);
      chk({nm, ".idx"}, int'(b0.page_idx), int'(idx));
      chk({nm, ".digit"}, int'(b0.digit), int'(d));
      chk({nm, ".blank"}, int'(b0.blank), int'(bl));
      chk({nm, ".tick"}, int'(b0.page_tick), int'(tk));
   endtask

   initial begin
      int ticks;
      int exp_idx;
      reset        = 1'b1;
      b0.sw        = '0;
      b0.auto_en   = 1'b0;
      b0.hold      = 1'b0;
      b0.page_data = 48'h15_14_13_12_11_10;
      b1.sw        = '0;
      b1.auto_en   = 1'b1;
      b1.hold      = 1'b0;
      b1.page_data = 48'h15_14_13_12_11_10;

      tv[0]  = '{7'h00, 1, 0, 3'd0, 8'h10, 0, 0};
      tv[1]  = '{7'h00, 1, 0, 3'd0, 8'h10, 0, 0};
      tv[2]  = '{7'h00, 1, 0, 3'd0, 8'h10, 0, 0};
      tv[3]  = '{7'h00, 1, 0, 3'd0, 8'h10, 0, 0};
      tv[4]  = '{7'h00, 1, 0, 3'd0, 8'h10, 1, 0};
      tv[5]  = '{7'h00, 1, 0, 3'd0, 8'h10, 1, 0};
      tv[6]  = '{7'h00, 1, 0, 3'd1, 8'h11, 0, 1};
      tv[7]  = '{7'h00, 1, 0, 3'd1, 8'h11, 0, 0};
      tv[8]  = '{7'h00, 1, 0, 3'd1, 8'h11, 0, 0};
      tv[9]  = '{7'h00, 1, 0, 3'd1, 8'h11, 0, 0};
      tv[10] = '{7'h00, 1, 0, 3'd1, 8'h11, 1, 0};
      tv[11] = '{7'h00, 1, 0, 3'd1, 8'h11, 1, 0};
      tv[12] = '{7'h00, 1, 0, 3'd2, 8'h12, 0, 1};
      tv[13] = '{7'h08, 1, 0, 3'd3, 8'h13, 0, 0};
      tv[14] = '{7'h00, 1, 0, 3'd3, 8'h13, 0, 0};
      tv[15] = '{7'h00, 1, 0, 3'd3, 8'h13, 0, 0};
      tv[16] = '{7'h00, 1, 0, 3'd3, 8'h13, 0, 0};
      tv[17] = '{7'h00, 1, 0, 3'd3, 8'h13, 0, 0};
      tv[18] = '{7'h00, 1, 0, 3'd3, 8'h13, 1, 0};
      tv[19] = '{7'h03, 0, 0, 3'd3, 8'h00, 0, 0};
      tv[20] = '{7'h40, 0, 0, 3'd3, 8'h00, 0, 0};

      step();
      chk_all("reset", 3'd0, 8'h00, 1'b0, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < 21; i++) begin
         b0.sw      = tv[i].sw;
         b0.auto_en = tv[i].ae;
         b0.hold    = tv[i].hold;
         step();
         chk_all($sformatf("vec%0d", i), tv[i].idx, tv[i].digit,
                 tv[i].blank, tv[i].tick);
      end

      // full rotation including the wrap from page 5 to page 0
      reset = 1'b1;
      b0.sw = '0;
      b0.auto_en = 1'b0;
      step();
      reset = 1'b0;
      b0.auto_en = 1'b1;
      ticks = 0;
      for (int c = 0; c < 60 && ticks < 6; c++) begin
         step();
         if (b0.page_tick) begin
            ticks++;
            exp_idx = ticks % 6;
            chk($sformatf("wrap.tick%0d", ticks),
                int'(b0.page_idx), exp_idx);
         end
      end
      chk("wrap.count", ticks, 6);

      // hold freezes the counter at 2
      reset = 1'b1;
      b0.auto_en = 1'b0;
      step();
      reset = 1'b0;
      b0.auto_en = 1'b1;
      step();
      step();
      step();
      b0.hold = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         chk($sformatf("hold%0d.tick", c), int'(b0.page_tick), 0);
         chk($sformatf("hold%0d.blank", c), int'(b0.blank), 0);
         chk($sformatf("hold%0d.idx", c), int'(b0.page_idx), 0);
      end
      b0.hold = 1'b0;
      step();
      chk("unhold1.blank", int'(b0.blank), 0);
      step();
      chk("unhold2.blank", int'(b0.blank), 1);

      // live page_data update while manual
      b0.sw = 7'b0000010;
      step();
      chk_all("man1", 3'd1, 8'h11, 1'b0, 1'b0);
      b0.page_data[15:8] = 8'hA5;
      step();
      chk("live.digit", int'(b0.digit), 32'hA5);

      // reset while blanking
      b0.sw = '0;
      step();
      step();
      step();
      step();
      step();
      chk("preblank.blank", int'(b0.blank), 1);
      reset = 1'b1;
      step();
      chk_all("rst_blank", 3'd0, 8'h00, 1'b0, 1'b0);
      reset = 1'b0;

      // no blank phase: advance every 4 cycles
      for (int c = 1; c <= 25; c++) begin
         step();
         chk($sformatf("nb%0d.blank", c), int'(b1.blank), 0);
         chk($sformatf("nb%0d.tick", c), int'(b1.page_tick),
             (c >= 5 && (c - 1) % 4 == 0) ? 1 : 0);
         chk($sformatf("nb%0d.idx", c), int'(b1.page_idx),
             ((c - 1) / 4) % 6);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fnd_page_scheduler.md
Name: fnd_page_scheduler

Overview:
Sequences which of the six 8-bit status registers drives the 4-digit FND controller. It replaces static switch selection with an auto-rotating page scheduler. Manual one-hot switch selection keeps priority over auto-rotation. The block sits between the AXI slave register bank and fnd_controller and drives its Digit input, plus a blank qualifier.

Parameters:
NUM_PAGES, 6, number of register pages; page_data holds NUM_PAGES*DATA_W bits
DATA_W, 8, width of each page and of digit
DWELL_CYCLES, 100_000_000, clk cycles each page is shown in auto mode (1 s at 100 MHz); must be >= 1
BLANK_CYCLES, 10_000_000, clk cycles the display is blanked between pages; 0 = no blank phase

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sw  input  7  manual page select, one-hot; bit k selects page k (k < NUM_PAGES)
auto_en  input  1  enables auto-rotation when no valid manual select is present
hold  input  1  freezes the auto dwell/blank counter and the current page
page_data  input  NUM_PAGES*DATA_W  packed pages; page k = page_data[k*DATA_W +: DATA_W]
digit  output  DATA_W  registered value to fnd_controller Digit
page_idx  output  3  index of the page currently selected
blank  output  1  1 = FND must be blanked (auto transition phase)
page_tick  output  1  one-cycle pulse when auto mode advances page_idx

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. Reset sets digit=0, page_idx=0, blank=0, page_tick=0, state=IDLE and the counter to 0. A reset asserted in mid-dwell or mid-blank aborts at the next edge.
- Valid manual select: sw has exactly one bit set, at a position < NUM_PAGES. Zero bits set, several bits set, or bit 6 set (with the default parameters) counts as no selection.
- FSM states: IDLE, MANUAL, AUTO_SHOW, AUTO_BLANK. These transitions are evaluated every cycle:
  - Any state -> MANUAL when sw is valid. page_idx takes the decoded index on the same edge. The counter clears.
  - MANUAL -> AUTO_SHOW when sw becomes invalid and auto_en=1. Rotation resumes from the last manual page with the counter at 0.
  - MANUAL -> IDLE when sw becomes invalid and auto_en=0.
  - IDLE -> AUTO_SHOW when auto_en=1. page_idx is kept and the counter is 0.
  - AUTO_SHOW or AUTO_BLANK -> IDLE when auto_en falls. The blank phase is abandoned and blank=0.
  - AUTO_SHOW: the counter increments each cycle when hold=0 and holds when hold=1. On the edge where the counter = DWELL_CYCLES-1 and hold=0, the counter clears:
    - if BLANK_CYCLES>0, go to AUTO_BLANK;
    - if BLANK_CYCLES=0, advance the page directly and stay in AUTO_SHOW.
  - AUTO_BLANK: the counter increments when hold=0. On the edge where the counter = BLANK_CYCLES-1 and hold=0: the counter clears, page_idx advances, and the state returns to AUTO_SHOW.
  - Page advance: page_idx = (page_idx == NUM_PAGES-1) ? 0 : page_idx+1. page_tick=1 for exactly that one cycle and is 0 otherwise.
- digit output:
  - MANUAL, AUTO_SHOW and AUTO_BLANK: digit <= page k of page_data, where k = the next-state page_idx. Latency is 1 cycle from a sw or page_data change to digit, so live register updates propagate while a page is shown.
  - IDLE: digit <= 0.
- blank output: blank=1 exactly while the registered state is AUTO_BLANK. digit still updates during blank; the consumer gates the display.
- Simultaneous events:
  - A valid sw in the same cycle as a dwell terminal: MANUAL wins, no page_tick.
  - hold=1 at a terminal: no transition and no tick until hold drops.
- Widths: the counter is $clog2(max(DWELL_CYCLES, BLANK_CYCLES, 2)) bits with no overflow. page_idx is compared and wrapped at NUM_PAGES-1, never at 7.

Decomposition:
- Shared package fnd_pkg holds:
  - the state enum (IDLE, MANUAL, AUTO_SHOW, AUTO_BLANK);
  - the NUM_PAGES and DATA_W defaults;
  - the function onehot_to_idx, which returns {valid, idx} for a 7-bit one-hot input.
- One sub-module, fnd_dwell_timer: a terminal-count counter with enable, synchronous clear and a runtime-selected limit (DWELL or BLANK), outputting the terminal pulse.
- Page mux and FSM stay in the top.

Test Plan:
All tests use DWELL_CYCLES=4, BLANK_CYCLES=2 and page k = 8'h10+k.
1. Reset, then sw=0, auto_en=1. Page 0 is held 4 cycles, then blank=1 for 2 cycles, then page_idx=1 with page_tick for one cycle. digit=8'h10, then 8'h11. After page 5 it wraps to page_idx=0.
2. In auto mode on page 2, set sw=7'b0001000. Next edge: page_idx=3, digit=8'h13, blank=0, no page_tick. Clear sw: AUTO_SHOW resumes at page 3 with a full 4-cycle dwell.
3. Set sw=7'b0000011, then 7'b1000000, each with auto_en=0. Both are invalid: state IDLE, digit=8'h00.
4. In AUTO_SHOW with the counter at 2, set hold=1 for 10 cycles. No tick and page_idx unchanged. Release hold: the transition happens 2 cycles later.
5. While MANUAL on page 1, change page_data byte 1 to 8'hA5. digit=8'hA5 one cycle later.
6. Assert reset during AUTO_BLANK. Next edge: blank=0, digit=0, page_idx=0. With BLANK_CYCLES=0, the page advances every 4 cycles and blank is never asserted.
